spi_rd_initiator: RTL and testbench

- Host-side SPI read sequencer; drives the 4-wire+DC link that feeds the device-side command decoder.
- On a request it issues a command byte with DC low (INFO_RD 0x3a or DATA_RD 0x3b), then clocks dummy bytes with DC high.
- Returned bytes are collected and presented as an indexed read stream.
- Sits between a host register front-end and a byte-level SPI shifter using a tx valid/ready handshake and an rx valid strobe.

---
 rtl/spi_rd_pkg.sv | 20 ++
 rtl/spi_rd_wdt.sv | 28 ++
 rtl/spi_rd_initiator.sv | 175 +++++++++++++++++
 tb/tb_spi_rd_initiator.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rd_pkg.sv
// Shared types for the SPI read initiator and the device-side command decoder.
package spi_rd_pkg;

    typedef enum logic [7:0] {
        INFO_RD = 8'h3a,
        DATA_RD = 8'h3b
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        WAIT_RX,
        DONE
    } state_t;

    localparam logic [3:0] BASE_INFO = 4'h0;
    localparam logic [3:0] BASE_DATA = 4'h8;

endpackage

// File: rtl/spi_rd_wdt.sv
// Inactivity watchdog: expires after LIMIT enabled cycles without a kick.
module spi_rd_wdt #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic kick_i,
    output logic expire_o
);
    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    // Expiry is combinational so the FSM aborts on exactly the LIMIT-th idle edge.
    assign expire_o = en_i & ~kick_i & (cnt_q == W'(LIMIT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (!en_i || kick_i || expire_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/spi_rd_initiator.sv
// Host-side SPI read sequencer: command byte, dummy data bytes, indexed read stream.
// Optional inactivity abort enabled by defining SPI_RD_TIMEOUT_EN.
module spi_rd_initiator
    import spi_rd_pkg::*;
#(
    parameter int unsigned INFO_LEN    = 7,
    parameter int unsigned DATA_LEN    = 7,
    parameter int unsigned RX_SKIP     = 1,
    parameter logic [7:0]  DUMMY       = 8'h00,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req_i,
    input  logic       req_type_i,
    output logic       req_rdy_o,
    output logic       cs_n_o,
    output logic       dc_o,
    output logic       tx_vld_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_rdy_i,
    input  logic       rx_vld_i,
    input  logic [7:0] rx_data_i,
    output logic       rd_vld_o,
    output logic [3:0] rd_addr_o,
    output logic [7:0] rd_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);
    localparam int unsigned MAX_LEN = (INFO_LEN > DATA_LEN) ? INFO_LEN : DATA_LEN;
    localparam int unsigned CW      = $clog2(2 + RX_SKIP + MAX_LEN);

    state_t        state_q;
    logic          type_q;
    logic [CW-1:0] tx_cnt_q;
    logic [CW-1:0] rx_cnt_q;
    logic          cs_n_q;
    logic          dc_q;
    logic          tx_vld_q;
    logic [7:0]    tx_data_q;
    logic          rd_vld_q;
    logic [3:0]    rd_addr_q;
    logic [7:0]    rd_data_q;
    logic          done_q;
    logic          err_q;

    logic [CW-1:0] len;
    logic [CW-1:0] tx_last;
    logic [CW-1:0] rx_total;
    logic [CW-1:0] pay_idx;
    logic [3:0]    base;
    logic          tx_hs;
    logic          rx_take;
    logic          timeout;

    always_comb begin
        len      = type_q ? CW'(DATA_LEN) : CW'(INFO_LEN);
        base     = type_q ? BASE_DATA : BASE_INFO;
        tx_last  = len + CW'(RX_SKIP) - CW'(1);
        rx_total = len + CW'(1 + RX_SKIP);
        pay_idx  = rx_cnt_q - CW'(1 + RX_SKIP);
    end

    assign tx_hs   = tx_vld_q & tx_rdy_i;
    assign rx_take = rx_vld_i && (state_q inside {CMD, DATA, WAIT_RX}) && (rx_cnt_q < rx_total);

    assign req_rdy_o = (state_q == IDLE);
    assign busy_o    = (state_q != IDLE);
    assign cs_n_o    = cs_n_q;
    assign dc_o      = dc_q;
    assign tx_vld_o  = tx_vld_q;
    assign tx_data_o = tx_data_q;
    assign rd_vld_o  = rd_vld_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

`ifdef SPI_RD_TIMEOUT_EN
    spi_rd_wdt #(
        .LIMIT(TIMEOUT_CYC)
    ) u_wdt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (busy_o),
        .kick_i  (tx_hs | rx_vld_i),
        .expire_o(timeout)
    );
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            type_q    <= 1'b0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            cs_n_q    <= 1'b1;
            dc_q      <= 1'b0;
            tx_vld_q  <= 1'b0;
            tx_data_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            if (timeout) begin
                state_q  <= IDLE;
                cs_n_q   <= 1'b1;
                tx_vld_q <= 1'b0;
                err_q    <= 1'b1;
            end else begin
                // Receive side counts independently of the tx phase; echo and skip bytes are dropped.
                if (rx_take) begin
                    rx_cnt_q <= rx_cnt_q + CW'(1);
                    if (rx_cnt_q > CW'(RX_SKIP)) begin
                        rd_vld_q  <= 1'b1;
                        rd_data_q <= rx_data_i;
                        rd_addr_q <= base + 4'(pay_idx);
                    end
                end
                case (state_q)
                    IDLE: begin
                        if (req_i) begin
                            type_q    <= req_type_i;
                            tx_cnt_q  <= '0;
                            rx_cnt_q  <= '0;
                            cs_n_q    <= 1'b0;
                            dc_q      <= 1'b0;
                            tx_vld_q  <= 1'b1;
                            tx_data_q <= req_type_i ? DATA_RD : INFO_RD;
                            state_q   <= CMD;
                        end
                    end
                    CMD: begin
                        if (tx_rdy_i) begin
                            dc_q      <= 1'b1;
                            tx_data_q <= DUMMY;
                            state_q   <= DATA;
                        end
                    end
                    DATA: begin
                        if (tx_rdy_i) begin
                            tx_cnt_q <= tx_cnt_q + CW'(1);
                            if (tx_cnt_q == tx_last) begin
                                tx_vld_q <= 1'b0;
                                state_q  <= WAIT_RX;
                            end
                        end
                    end
                    WAIT_RX: begin
                        if (rx_cnt_q == rx_total) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                    DONE: begin
                        cs_n_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_rd_initiator.sv
// Scoreboard bench for spi_rd_initiator: a shifter model echoes bytes two cycles after each tx handshake.
`timescale 1ns/1ps
module tb_spi_rd_initiator;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       req_type;
    logic       req_rdy_o;
    logic       cs_n_o;
    logic       dc_o;
    logic       tx_vld_o;
    logic [7:0] tx_data_o;
    logic       tx_rdy;
    logic       rx_vld;
    logic [7:0] rx_data;
    logic       rd_vld_o;
    logic [3:0] rd_addr_o;
    logic [7:0] rd_data_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    spi_rd_initiator #(
        .INFO_LEN   (7),
        .DATA_LEN   (7),
        .RX_SKIP    (1),
        .DUMMY      (8'h00),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .req_type_i(req_type),
        .req_rdy_o (req_rdy_o),
        .cs_n_o    (cs_n_o),
        .dc_o      (dc_o),
        .tx_vld_o  (tx_vld_o),
        .tx_data_o (tx_data_o),
        .tx_rdy_i  (tx_rdy),
        .rx_vld_i  (rx_vld),
        .rx_data_i (rx_data),
        .rd_vld_o  (rd_vld_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_o (rd_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_seen = 0;
    int done_exp = 0;
    int err_seen = 0;
    int err_exp = 0;
    int hs_idx = 0;
    int rx_limit = 1000;
    int last_evt = 0;
    logic [7:0] rx_base = 8'h00;
    logic       stall_mode = 1'b0;

    logic [8:0]  tx_q[$];
    logic [11:0] rd_q[$];
    int          pend_t[$];
    logic [7:0]  pend_d[$];

    logic       prev_stall = 1'b0;
    logic       prev_dc;
    logic [7:0] prev_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d required finish", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shifter model: tx_rdy pattern and delayed rx strobes.
    initial begin
        tx_rdy  = 1'b1;
        rx_vld  = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            tx_rdy = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
            if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
                rx_vld  = 1'b1;
                rx_data = pend_d.pop_front();
                void'(pend_t.pop_front());
            end else begin
                rx_vld = 1'b0;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a tx byte or a read beat.
    initial begin
        logic [8:0]  etx;
        logic [11:0] erd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall)
                check("tx_hold", {23'd0, tx_vld_o, dc_o, tx_data_o}, {23'd0, 1'b1, prev_dc, prev_data});
            prev_stall = tx_vld_o & ~tx_rdy;
            prev_dc    = dc_o;
            prev_data  = tx_data_o;
            if (tx_vld_o && tx_rdy) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", {23'd0, dc_o, tx_data_o}, 32'hffffffff);
                end else begin
                    etx = tx_q.pop_front();
                    check("tx_byte", {23'd0, dc_o, tx_data_o}, {23'd0, etx});
                end
                hs_idx = dc_o ? hs_idx + 1 : 0;
                if (hs_idx < rx_limit) begin
                    pend_t.push_back(cyc + 2);
                    pend_d.push_back(rx_base + 8'(hs_idx));
                end
                last_evt = cyc + 1;
            end
            if (rd_vld_o) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", {20'd0, rd_addr_o, rd_data_o}, 32'hffffffff);
                end else begin
                    erd = rd_q.pop_front();
                    check("rd_beat", {20'd0, rd_addr_o, rd_data_o}, {20'd0, erd});
                end
            end
            if (done_o) done_seen++;
            if (err_o)  err_seen++;
        end
    end

    task automatic push_exp(input logic t, input logic [7:0] rxb);
        tx_q.push_back({1'b0, t ? 8'h3b : 8'h3a});
        for (int i = 0; i < 8; i++) tx_q.push_back(9'h100);
        for (int i = 0; i < 7; i++)
            rd_q.push_back({(t ? 4'h8 : 4'h0) + 4'(i), rxb + 8'(i + 2)});
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (req_rdy_o) return;
        end
        check("idle_wait_expired", {31'd0, req_rdy_o}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (done_o) return;
        end
        check(name, {31'd0, done_o}, 32'd1);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check(name, {29'd0, req_rdy_o, cs_n_o, busy_o}, {29'd0, 1'b1, 1'b1, 1'b0});
    endtask

    task automatic issue(input logic t, input logic [7:0] rxb);
        wait_idle();
        @(posedge clk);
        #1;
        rx_base  = rxb;
        push_exp(t, rxb);
        req_type = t;
        req      = 1'b1;
        done_exp++;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic flush();
        tx_q.delete();
        rd_q.delete();
        pend_t.delete();
        pend_d.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 1'b0;
        req_type = 1'b0;
        #12;
        check("reset_outputs",
              {20'd0, cs_n_o, dc_o, tx_vld_o, rd_vld_o, busy_o, done_o, err_o, req_rdy_o, 4'd0},
              {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
        check("reset_data", {12'd0, tx_data_o, rd_addr_o, rd_data_o}, 32'd0);
        #6;
        rst_n = 1'b1;

        // INFO_RD, no stalls
        issue(1'b0, 8'h50);
        wait_done("done_info");
        check_idle("idle_after_info");

        // DATA_RD, addresses 8..e
        issue(1'b1, 8'hA0);
        wait_done("done_data");
        check_idle("idle_after_data");

        // Random tx stalls
        stall_mode = 1'b1;
        issue(1'b1, 8'h30);
        wait_done("done_stall_data");
        check_idle("idle_after_stall_data");
        issue(1'b0, 8'h40);
        wait_done("done_stall_info");
        check_idle("idle_after_stall_info");
        stall_mode = 1'b0;

        // req_i held high across two back-to-back transactions
        wait_idle();
        @(posedge clk);
        #1;
        rx_base = 8'h10;
        push_exp(1'b0, 8'h10);
        req_type = 1'b0;
        req      = 1'b1;
        done_exp++;
        wait_done("done_hold_info");
        rx_base = 8'h20;
        push_exp(1'b1, 8'h20);
        req_type = 1'b1;
        done_exp++;
        wait_done("done_hold_data");
        req = 1'b0;
        check_idle("idle_after_hold");
        repeat (3) @(negedge clk);
        check("no_extra_accept", {31'd0, busy_o}, 32'd0);

        // Reset mid-DATA
        wait_idle();
        @(posedge clk);
        #1;
        rx_base = 8'hC0;
        push_exp(1'b1, 8'hC0);
        req_type = 1'b1;
        req      = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {20'd0, cs_n_o, dc_o, tx_vld_o, rd_vld_o, busy_o, done_o, err_o, req_rdy_o, 4'd0},
              {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
        check("midreset_data", {12'd0, tx_data_o, rd_addr_o, rd_data_o}, 32'd0);
        flush();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        issue(1'b0, 8'h70);
        wait_done("done_after_reset");
        check_idle("idle_after_reset");

`ifdef SPI_RD_TIMEOUT_EN
        // rx stops after 3 bytes; watchdog aborts 16 cycles after the last tx handshake
        wait_idle();
        @(posedge clk);
        #1;
        rx_limit = 3;
        rx_base  = 8'h90;
        tx_q.push_back({1'b0, 8'h3a});
        for (int i = 0; i < 8; i++) tx_q.push_back(9'h100);
        rd_q.push_back({4'h0, 8'h92});
        req_type = 1'b0;
        req      = 1'b1;
        err_exp++;
        @(posedge clk);
        #1;
        req = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 200 && !seen; n++) begin
                @(negedge clk);
                if (err_o) begin
                    seen = 1'b1;
                    check("timeout_latency", 32'(cyc - last_evt), 32'd16);
                end
            end
            check("timeout_err_seen", {31'd0, seen}, 32'd1);
        end
        check_idle("idle_after_timeout");
        rx_limit = 1000;
`endif

        repeat (5) @(negedge clk);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'(done_exp));
        check("err_count", 32'(err_seen), 32'(err_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
